elastic_register_chain: RTL
===========================

Name: elastic_register_chain

Overview:
- Parametrised successor to the fixed register delay chain.
- Moves WIDTH-bit words through STAGES register stages. Each stage carries its own valid bit.
- Adds valid/ready backpressure, bubble collapsing and a synchronous flush.
- Sits between multiplier pipeline segments and downstream consumers that can stall, so partial products are never dropped or duplicated.

Parameters:
- WIDTH, 5, data word width in bits (>=1).
- STAGES, 5, number of register stages and the no-stall latency in cycles (>=1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all stage valids.
- in_data  input  WIDTH  input word.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  chain accepts in_data this cycle.
- out_data  output  WIDTH  word held in the last stage.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer takes out_data this cycle.
- occupancy  output  $clog2(STAGES+1)  present only with ELASTIC_CHAIN_OCC_EN.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- State:
  - Stage i, for i = 0..STAGES-1, holds d[i] (WIDTH bits) and v[i] (1 bit).
  - Stage 0 is the input end; stage STAGES-1 drives out_data and out_valid.
- Reset: while rst=1, all v[i]=0 and all d[i]=0, immediately and without waiting for clk. So out_valid=0, out_data=0 and in_ready=1.
- Accept terms (combinational):
  - acc[STAGES-1] = !v[STAGES-1] | out_ready.
  - acc[i] = !v[i] | acc[i+1].
  - in_ready = acc[0] & !flush.
- Transfer on each clk edge when flush=0:
  - if acc[i], then d[i] <= src and v[i] <= src_valid, where the source is stage i-1, or in_data/in_valid for i=0.
  - if !acc[i], stage i holds.
  - d[i] may load from an invalid source. Data content of invalid stages is don't-care apart from reset.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- Latency: with out_ready held at 1, a word accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles of register delay. This matches the old fixed chain.
- Throughput: one word per cycle when out_ready=1.
- Bubble collapsing: under a stall, empty stages keep filling until the chain holds STAGES words. Then in_ready=0.
- Full chain (all v=1) with out_ready=1: out word retires, every stage shifts, and in_ready=1 in the same cycle.
- Empty chain: out_valid=0. out_ready is ignored.
- Flush (synchronous):
  - At the edge with flush=1, all v[i] <= 0. d[i] is unchanged.
  - in_ready=0 during flush, so no input is accepted; in_valid is ignored.
  - An out transfer in the flush cycle still counts if out_valid & out_ready.
- flush together with rst: rst dominates.
- rst asserted mid-stream: all in-flight words are lost. After rst deasserts, first acceptance is on the next edge with in_valid=1.
- The ready path is combinational from out_ready through all stages to in_ready. STAGES is chosen small enough to close timing.
- No word is lost or duplicated except by flush or rst.

Optional Feature:
- Macro ELASTIC_CHAIN_OCC_EN.
- Defined:
  - occupancy port exists and equals the registered count of v[i]=1, ranging 0..STAGES.
  - It updates as +1 on input transfer and -1 on output transfer; both in one cycle leaves it unchanged.
  - Reset value is 0. Flush sets it to 0, ignoring any transfers in that cycle.
  - The bench asserts occupancy == popcount(v) every cycle.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset: rst=1 mid-cycle with words in flight -> out_valid=0, out_data=0, in_ready=1 immediately (async); occupancy=0.
- Streaming (WIDTH=8, STAGES=5, out_ready=1): send 0x01..0x10 back-to-back -> 0x01 valid 5 cycles after acceptance, then 0x02..0x10 on consecutive cycles in order, none missing.
- Stall fill: out_ready=0, in_valid=1 with 0xA0..0xA6 -> 0xA0..0xA4 accepted, in_ready=0 afterwards, out_data=0xA0 stable; raise out_ready -> 0xA0..0xA6 emerge in order with no gaps.
- Bubbles: in_valid alternates 1/0, out_ready toggles pseudo-randomly over 200 cycles -> scoreboard: output sequence equals input sequence; out_data stable while stalled.
- Flush: 3 words in flight, flush=1 for one cycle with in_valid=1 data 0x55 -> in_ready=0 that cycle, out_valid=0 next cycle, 0x55 never emerges; next word sent emerges after 5 cycles.
- STAGES=1 edge case: full stage with out_ready=1 and in_valid=1 -> retire and accept in the same cycle, giving one word per cycle.

Source files
------------

// File: rtl/elastic_register_chain.sv
// elastic_register_chain
// WIDTH-bit words move through STAGES register stages. Each stage has its own
// valid bit. The chain supports valid/ready backpressure, bubble collapsing
// and a synchronous flush.
// Optional build macro ELASTIC_CHAIN_OCC_EN adds a registered occupancy
// counter and its output port. With the macro undefined, the port and the
// counter are absent.
module elastic_register_chain #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef ELASTIC_CHAIN_OCC_EN
  ,
  output logic [$clog2(STAGES+1)-1:0] occupancy
`endif
);

  // Per-stage payload and valid state; stage 0 is the input end.
  logic [WIDTH-1:0]  data_reg [STAGES];
  logic [STAGES-1:0] valid_reg;

  // Per-stage accept term and the word each stage would load.
  logic [STAGES-1:0] acc;
  logic [WIDTH-1:0]  src_data [STAGES];
  logic [STAGES-1:0] src_valid;

  // The last stage can load when it is empty or when the consumer takes its word.
  always_comb begin
    acc[STAGES-1] = !valid_reg[STAGES-1] | out_ready;
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES - 1; gi++) begin : g_acc
      // A stage can load when it is empty or when its successor moves on.
      // This ripples the ready path combinationally from out_ready back to stage 0.
      always_comb begin
        acc[gi] = !valid_reg[gi] | acc[gi+1];
      end
    end

    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_src_in
        // Stage 0 takes its word from the chain input.
        always_comb begin
          src_data[gi]  = in_data;
          src_valid[gi] = in_valid;
        end
      end else begin : g_src_prev
        // Later stages take the word from the previous stage.
        always_comb begin
          src_data[gi]  = data_reg[gi-1];
          src_valid[gi] = valid_reg[gi-1];
        end
      end

      // Stage register: clear on reset, drop valid on flush, load when accepting, else hold.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg[gi]  <= '0;
          valid_reg[gi] <= 1'b0;
        end else if (flush) begin
          valid_reg[gi] <= 1'b0;
        end else if (acc[gi]) begin
          data_reg[gi]  <= src_data[gi];
          valid_reg[gi] <= src_valid[gi];
        end
      end
    end
  endgenerate

  // Drive the outputs from the tail stage. Input is refused during a flush,
  // because the word would be discarded anyway.
  always_comb begin
    out_data  = data_reg[STAGES-1];
    out_valid = valid_reg[STAGES-1];
    in_ready  = acc[0] & !flush;
  end

`ifdef ELASTIC_CHAIN_OCC_EN
  localparam int OCC_W = $clog2(STAGES + 1);

  logic             in_xfer;
  logic             out_xfer;
  logic [OCC_W-1:0] occ_reg;
  logic [OCC_W-1:0] occ_next;

  // Next occupancy: +1 per input transfer and -1 per output transfer.
  // A flush clears the count and ignores same-cycle transfers.
  always_comb begin
    in_xfer  = in_valid & in_ready;
    out_xfer = out_valid & out_ready;
    occ_next = occ_reg;
    if (flush) begin
      occ_next = '0;
    end else if (in_xfer && !out_xfer) begin
      occ_next = occ_reg + 1'b1;
    end else if (out_xfer && !in_xfer) begin
      occ_next = occ_reg - 1'b1;
    end
  end

  // Occupancy counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_next;
    end
  end

  assign occupancy = occ_reg;
`endif

endmodule
